// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out word receiver.
// Rebuilds WIDTH-bit words sent MSB-first over a strobed bit-serial line.
// Each frame is a start bit (0), WIDTH data bits, an optional even-parity
// bit and a stop bit (1). A good frame updates Q and pulses Valid for one
// cycle. A bad stop bit pulses FrameErr, and a parity mismatch pulses
// ParityErr. Q keeps the last good word until the next good frame.

module serial_word_receiver #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             SerIn,
    input  logic             SerValid,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             FrameErr,
    output logic             ParityErr,
    output logic             Busy
);

    // The counter must be able to hold WIDTH itself: it is incremented on
    // every data bit, including the last one.
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Even parity: the data bits and the parity bit must XOR to zero.
    function automatic logic even_parity_ok(input logic [WIDTH-1:0] data,
                                            input logic             par);
        return ((^data) ^ par) == 1'b0;
    endfunction

    // Registered state
    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   shift_r;
    logic               par_r;
    logic [WIDTH-1:0]   q_r;
    logic               valid_r;
    logic               frame_err_r;
    logic               parity_err_r;
    logic               busy_r;

    // Next-state values
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_s;
    logic [WIDTH-1:0]   shift_s;
    logic               par_s;
    logic [WIDTH-1:0]   q_s;
    logic               valid_s;
    logic               frame_err_s;
    logic               parity_err_s;
    logic               busy_s;
    logic               parity_ok_s;
    logic               last_bit_s;

    // Next-state and pulse logic. State only moves on SerValid strobes.
    // The pulse outputs fall back to 0 on every cycle that does not
    // finish a frame.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        shift_s      = shift_r;
        par_s        = par_r;
        q_s          = q_r;
        valid_s      = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
        last_bit_s   = (cnt_r == CNT_W'(WIDTH - 1));

        // Without a parity bit the frame is always parity-clean.
        if (PARITY_EN) begin
            parity_ok_s = even_parity_ok(shift_r, par_r);
        end else begin
            parity_ok_s = 1'b1;
        end

        if (SerValid) begin
            case (state_r)
                ST_IDLE: begin
                    if (SerIn == 1'b0) begin
                        state_s = ST_DATA;
                        cnt_s   = '0;
                        shift_s = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // Shift left: the first data bit ends up in the MSB.
                    shift_s = {shift_r[WIDTH-2:0], SerIn};
                    cnt_s   = cnt_r + CNT_W'(1);
                    if (last_bit_s) begin
                        if (PARITY_EN) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_STOP;
                        end
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_s   = SerIn;
                    state_s = ST_STOP;
                end
                ST_STOP: begin
                    state_s = ST_IDLE;
                    if ((SerIn == 1'b1) && parity_ok_s) begin
                        q_s     = shift_r;
                        valid_s = 1'b1;
                    end else begin
                        frame_err_s  = ~SerIn;
                        parity_err_s = ~parity_ok_s;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers. Reset aborts any frame in progress.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            shift_r      <= '0;
            par_r        <= 1'b0;
            q_r          <= '0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            shift_r      <= shift_s;
            par_r        <= par_s;
            q_r          <= q_s;
            valid_r      <= valid_s;
            frame_err_r  <= frame_err_s;
            parity_err_r <= parity_err_s;
            busy_r       <= busy_s;
        end
    end

    assign Q         = q_r;
    assign Valid     = valid_r;
    assign FrameErr  = frame_err_r;
    assign ParityErr = parity_err_r;
    assign Busy      = busy_r;

endmodule
